// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Groups the CPU MEM-stage port, the IO port and the data RAM port of the
//   data memory arbiter.
//   master : the arbiter side. It takes requests, drives the RAM and returns data.
//   slave  : the environment side, made up of the CPU, the IO controller and the RAM.
//   CPU : cpuReq, cpuWe, cpuAddr, cpuWdata -> cpuStall, cpuRdata
//   IO  : ioReq, ioWe, ioAddr, ioWdata     -> ioGnt, ioRdata, ioRvalid
//   RAM : memAddr, memWdata, memWe         <- memRdata (1-cycle latency)
interface data_mem_arbiter_if #(
    parameter int WIDTH        = 24,
    parameter int MEMADDRWIDTH = 10
);
    logic                    cpuReq;
    logic                    cpuWe;
    logic [MEMADDRWIDTH-1:0] cpuAddr;
    logic [WIDTH-1:0]        cpuWdata;
    logic                    cpuStall;
    logic [WIDTH-1:0]        cpuRdata;

    logic                    ioReq;
    logic                    ioWe;
    logic [MEMADDRWIDTH-1:0] ioAddr;
    logic [WIDTH-1:0]        ioWdata;
    logic                    ioGnt;
    logic [WIDTH-1:0]        ioRdata;
    logic                    ioRvalid;

    logic [MEMADDRWIDTH-1:0] memAddr;
    logic [WIDTH-1:0]        memWdata;
    logic                    memWe;
    logic [WIDTH-1:0]        memRdata;

    modport master (
        input  cpuReq, cpuWe, cpuAddr, cpuWdata,
        output cpuStall, cpuRdata,
        input  ioReq, ioWe, ioAddr, ioWdata,
        output ioGnt, ioRdata, ioRvalid,
        output memAddr, memWdata, memWe,
        input  memRdata
    );

    modport slave (
        output cpuReq, cpuWe, cpuAddr, cpuWdata,
        input  cpuStall, cpuRdata,
        output ioReq, ioWe, ioAddr, ioWdata,
        input  ioGnt, ioRdata, ioRvalid,
        input  memAddr, memWdata, memWe,
        output memRdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port data RAM between the CPU MEM stage and the IO port.
//   The CPU wins by default. An IO request that has waited STARVELIMIT
//   consecutive cycles is forced through. The CPU then sees cpuStall for that
//   cycle and retries on the next one.
//   Ports:
//     clock : rising-edge system clock
//     reset : asynchronous active-low reset
//     bus   : data_mem_arbiter_if.master (CPU, IO and RAM signal groups)
//   STARVELIMIT must lie in 1..15 because the wait counter is 4 bits wide.
module data_mem_arbiter #(
    parameter int WIDTH        = 24,
    parameter int MEMADDRWIDTH = 10,
    parameter int STARVELIMIT  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_arbiter_if.master   bus
);
    localparam logic [3:0] LIMIT = 4'(STARVELIMIT);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_IO   = 2'd2
    } owner_t;

    logic [3:0] starveCnt, starveCntNext;
    owner_t     rdOwner, rdOwnerNext;
    logic       ioWin, cpuWin;

    // Winner selection
    always_comb begin
        ioWin  = bus.ioReq && (!bus.cpuReq || starveCnt == LIMIT);
        cpuWin = bus.cpuReq && !ioWin;
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starveCnt <= 4'd0;
            rdOwner   <= OWN_NONE;
        end else begin
            starveCnt <= starveCntNext;
            rdOwner   <= rdOwnerNext;
        end
    end

    // Next state
    always_comb begin
        starveCntNext = 4'd0;
        if (bus.ioReq && !ioWin)
            starveCntNext = (starveCnt == LIMIT) ? LIMIT : starveCnt + 4'd1;

        rdOwnerNext = OWN_NONE;
        if (ioWin && !bus.ioWe)
            rdOwnerNext = OWN_IO;
        else if (cpuWin && !bus.cpuWe)
            rdOwnerNext = OWN_CPU;
    end

    // Outputs. The winner-derived outputs are held at zero while reset is low,
    // so nothing reaches the RAM during reset.
    always_comb begin
        bus.ioGnt    = 1'b0;
        bus.cpuStall = 1'b0;
        bus.memWe    = 1'b0;
        bus.memAddr  = '0;
        bus.memWdata = '0;
        if (reset) begin
            bus.ioGnt    = ioWin;
            bus.cpuStall = bus.cpuReq && ioWin;
            if (ioWin) begin
                bus.memWe    = bus.ioWe;
                bus.memAddr  = bus.ioAddr;
                bus.memWdata = bus.ioWdata;
            end else if (cpuWin) begin
                bus.memWe    = bus.cpuWe;
                bus.memAddr  = bus.cpuAddr;
                bus.memWdata = bus.cpuWdata;
            end
        end
    end

    // Read data passes straight through. The CPU pipeline knows when it
    // issued a read. IO gets a valid pulse from the registered read owner,
    // which the asynchronous reset clears.
    assign bus.cpuRdata = bus.memRdata;
    assign bus.ioRdata  = bus.memRdata;
    assign bus.ioRvalid = (rdOwner == OWN_IO);
endmodule

// File: tb/tb_data_mem_arbiter.sv
module tb_data_mem_arbiter;
    localparam int W   = 24;
    localparam int AW  = 10;
    localparam int LIM = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    data_mem_arbiter_if #(.WIDTH(W), .MEMADDRWIDTH(AW)) bus();

    data_mem_arbiter #(.WIDTH(W), .MEMADDRWIDTH(AW), .STARVELIMIT(LIM)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Physical RAM driven by the DUT: write at the edge, read data 1 cycle later.
    logic [W-1:0] ram [0:(1<<AW)-1];
    always @(posedge clock) begin
        if (bus.memWe) ram[bus.memAddr] <= bus.memWdata;
        bus.memRdata <= ram[bus.memAddr];
    end

    typedef struct {
        int           cyc;
        logic [W-1:0] data;
    } exp_t;

    exp_t         ioQ[$];
    exp_t         cpuQ[$];
    logic [W-1:0] refMem [0:(1<<AW)-1];
    int           modelWait = 0;
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    bit           rstDrv = 1'b0;
    bit           lastIoGnt, lastStall;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // One clock cycle. The inputs are driven just after the edge, and the
    // combinational outputs are checked before the next edge, against a model
    // that decides the owner of that next edge.
    task automatic step(input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [W-1:0] cd,
                        input bit ir, input bit iw, input logic [AW-1:0] ia, input logic [W-1:0] id);
        bit eIo, eCpu, eWe;
        logic [AW-1:0] eAddr;
        logic [W-1:0]  eWd;
        @(posedge clock);
        #1;
        reset        = rstDrv;
        bus.cpuReq   = cr; bus.cpuWe = cw; bus.cpuAddr = ca; bus.cpuWdata = cd;
        bus.ioReq    = ir; bus.ioWe  = iw; bus.ioAddr  = ia; bus.ioWdata  = id;
        // IO gets through when the CPU is idle or after LIM straight losses.
        eIo  = rstDrv && ir && (!cr || modelWait >= LIM);
        eCpu = rstDrv && cr && !eIo;
        eWe = 1'b0; eAddr = '0; eWd = '0;
        if (eIo) begin eWe = iw; eAddr = ia; eWd = id; end
        else if (eCpu) begin eWe = cw; eAddr = ca; eWd = cd; end
        #2;
        chk("ioGnt",    32'(bus.ioGnt),    32'(eIo));
        chk("cpuStall", 32'(bus.cpuStall), 32'(rstDrv && cr && eIo));
        chk("memWe",    32'(bus.memWe),    32'(eWe));
        chk("memAddr",  32'(bus.memAddr),  32'(eAddr));
        chk("memWdata", 32'(bus.memWdata), 32'(eWd));
        lastIoGnt = bus.ioGnt;
        lastStall = bus.cpuStall;
        if (rstDrv) begin
            if (eIo) begin
                if (iw) refMem[ia] = id;
                else    ioQ.push_back('{cyc + 1, refMem[ia]});
            end else if (eCpu) begin
                if (cw) refMem[ca] = cd;
                else    cpuQ.push_back('{cyc + 1, refMem[ca]});
            end
            modelWait = (ir && !eIo) ? modelWait + 1 : 0;
        end
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0);
    endtask

    // Monitor: read data and ioRvalid are checked against the scoreboard queues.
    always @(negedge clock) begin
        while (ioQ.size() > 0 && ioQ[0].cyc < cyc) begin
            tests++; fails++;
            $display("FAIL ioRvalid_missing @cyc %0d: got 0 expected 1 (due cyc %0d)", cyc, ioQ[0].cyc);
            void'(ioQ.pop_front());
        end
        if (bus.ioRvalid) begin
            if (ioQ.size() == 0 || ioQ[0].cyc != cyc) begin
                tests++; fails++;
                $display("FAIL ioRvalid_spurious @cyc %0d: got 1 expected 0", cyc);
            end else begin
                chk("ioRdata", 32'(bus.ioRdata), 32'(ioQ[0].data));
                void'(ioQ.pop_front());
            end
        end
        while (cpuQ.size() > 0 && cpuQ[0].cyc < cyc) void'(cpuQ.pop_front());
        if (cpuQ.size() > 0 && cpuQ[0].cyc == cyc) begin
            chk("cpuRdata", 32'(bus.cpuRdata), 32'(cpuQ[0].data));
            void'(cpuQ.pop_front());
        end
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]    = '0;
            refMem[i] = '0;
        end
        bus.cpuReq = 0; bus.cpuWe = 0; bus.cpuAddr = '0; bus.cpuWdata = '0;
        bus.ioReq  = 0; bus.ioWe  = 0; bus.ioAddr  = '0; bus.ioWdata  = '0;

        // Reset with both requesters active: every output must stay quiet.
        rstDrv = 1'b0;
        repeat (3) step(1, 1, 10'd7, 24'h111111, 1, 0, 10'd8, 24'h222222);
        chk("rst_ioRvalid", 32'(bus.ioRvalid), 32'd0);
        // Release: the CPU takes the first cycle.
        rstDrv = 1'b1;
        step(1, 0, 10'd7, 24'h0, 1, 0, 10'd8, 24'h0);
        chk("rel_cpuFirst", 32'(lastIoGnt), 32'd0);
        idle();
        idle();

        // CPU only: write, then read back.
        step(1, 1, 10'd5, 24'h00ABCD, 0, 0, '0, '0);
        step(1, 0, 10'd5, 24'h0, 0, 0, '0, '0);
        idle();
        chk("cpuRead_0xABCD", 32'(bus.cpuRdata), 32'h00ABCD);

        // IO only: write to the top address, then read back.
        step(0, 0, '0, '0, 1, 1, 10'h3FF, 24'h123456);
        step(0, 0, '0, '0, 1, 0, 10'h3FF, 24'h0);
        idle();
        idle();

        // Contention: IO gets exactly one slot in every LIM+1 cycles.
        for (int i = 0; i < 12; i++) begin
            step(1, 0, 10'd5, '0, 1, 0, 10'h3FF, '0);
            chk($sformatf("cont_ioGnt_%0d", i + 1), 32'(lastIoGnt), 32'((i % (LIM + 1)) == LIM));
            chk($sformatf("cont_stall_%0d", i + 1), 32'(lastStall), 32'((i % (LIM + 1)) == LIM));
        end
        idle();

        // Simultaneous request at count 0: the CPU wins. Then IO drops at count 2.
        step(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
        chk("simul_cpuWins", 32'(lastIoGnt), 32'd0);
        step(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
        step(1, 0, 10'd1, '0, 0, 0, 10'd2, '0);
        // After the drop the count starts again: LIM CPU wins, then one IO win.
        for (int i = 0; i <= LIM; i++) begin
            step(1, 0, 10'd1, '0, 1, 1, 10'd3, 24'h0F0F0F);
            chk($sformatf("drop_ioGnt_%0d", i), 32'(lastIoGnt), 32'(i == LIM));
        end
        idle();

        // Reset mid-read: the IO read is granted, and reset falls before the edge.
        step(0, 0, '0, '0, 1, 0, 10'd3, '0);
        #1;
        reset = 1'b0;
        rstDrv = 1'b0;
        ioQ.delete();
        modelWait = 0;
        idle();
        chk("midrst_ioRvalid", 32'(bus.ioRvalid), 32'd0);
        rstDrv = 1'b1;
        idle();
        idle();
        chk("post_rst_ioRvalid", 32'(bus.ioRvalid), 32'd0);

        // Randomized traffic over a small address window, so reads hit prior writes.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 15)), W'($urandom),
                 ($urandom_range(0, 2) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 15)), W'($urandom));
        end
        repeat (3) idle();
        chk("ioQ_drained", 32'(ioQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU pipeline MEM stage and the external IO port that loads and dumps data around startIO/outFlag.
- The CPU has default priority. A starvation counter guarantees the IO port a slot, and the CPU is stalled through cpuStall into the hazard unit while IO holds the RAM.
- The block sits between the CPU MEM stage, the IO controller and the data RAM. The RAM has 1-cycle read latency.

Parameters:
- WIDTH, 24, data word width
- MEMADDRWIDTH, 10, data RAM address width
- STARVELIMIT, 4, consecutive IO wait cycles before IO is forced to win (range 1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cpuReq  in  1  CPU MEM stage needs RAM this cycle
- cpuWe  in  1  CPU write (1) / read (0)
- cpuAddr  in  MEMADDRWIDTH  CPU address
- cpuWdata  in  WIDTH  CPU write data
- cpuStall  out  1  CPU must hold MEM and earlier stages this cycle
- cpuRdata  out  WIDTH  CPU read data, valid the cycle after a granted CPU read
- ioReq  in  1  IO request, held until granted
- ioWe  in  1  IO write / read
- ioAddr  in  MEMADDRWIDTH  IO address
- ioWdata  in  WIDTH  IO write data
- ioGnt  out  1  IO request accepted this cycle
- ioRdata  out  WIDTH  IO read data
- ioRvalid  out  1  ioRdata valid (1-cycle pulse)
- memAddr  out  MEMADDRWIDTH  RAM address
- memWdata  out  WIDTH  RAM write data
- memWe  out  1  RAM write enable
- memRdata  in  WIDTH  RAM read data, 1 cycle after address

Behaviour:
- State registers:
  - starveCnt: 4 bits, saturating.
  - rdOwner: 2 bits, encoded NONE/CPU/IO; records who issued the last-cycle read.
  - ioRvalid: registered output.
- While reset=0:
  - starveCnt=0, rdOwner=NONE, ioRvalid=0.
  - Combinational outputs are forced: ioGnt=0, cpuStall=0, memWe=0, memAddr=0, memWdata=0.
- Winner selection is combinational, evaluated every cycle:
  - ioWin = ioReq && (!cpuReq || starveCnt==STARVELIMIT).
  - cpuWin = cpuReq && !ioWin.
- Outputs derived from the winner:
  - ioGnt = ioWin.
  - cpuStall = cpuReq && ioWin.
  - memAddr/memWdata/memWe come from the winner; memWe = winner's We.
  - With no winner: memWe=0, memAddr=0, memWdata=0.
- starveCnt update:
  - ioReq && !ioWin: increment, saturating at STARVELIMIT.
  - ioWin or !ioReq: clear to 0.
- rdOwner (next) = IO if ioWin && !ioWe; CPU if cpuWin && !cpuWe; else NONE.
- Read return:
  - cpuRdata = memRdata unconditionally; it is meaningful only when rdOwner==CPU.
  - ioRdata = memRdata.
  - ioRvalid = registered (ioWin && !ioWe); it is high exactly the cycle after an IO read grant.
- Latency: grant-to-data is 1 cycle for both requesters. A write completes at the grant edge.
- Fairness boundaries:
  - With cpuReq held high continuously, IO wins exactly once every STARVELIMIT+1 cycles.
  - A forced IO win stalls the CPU for exactly 1 cycle; the CPU retries automatically because its request stays asserted under stall.
- Simultaneous events:
  - Both requesters request and starveCnt<STARVELIMIT: the CPU wins.
  - Both request and starveCnt==STARVELIMIT: IO wins and starveCnt clears.
- ioReq dropped before grant: starveCnt clears, and no grant or valid is produced.
- Back-to-back IO reads with no CPU traffic: ioGnt every cycle and ioRvalid every cycle, 1 cycle behind.
- Reset asserted mid-read: the pending ioRvalid is discarded, and no stale valid appears after reset release.

Test Plan:
- Reset: hold reset=0 with ioReq=1, cpuReq=1 -> ioGnt=0, cpuStall=0, memWe=0, ioRvalid=0; release -> CPU wins the first cycle.
- CPU only: CPU write 0x00ABCD to addr 5, then read addr 5 -> memWe=1 on the write cycle; cpuRdata=0x00ABCD the cycle after the read; cpuStall=0 throughout.
- IO only: IO write 0x123456 to addr 0x3FF, then read -> ioGnt on both cycles; ioRvalid pulses once with ioRdata=0x123456.
- Contention, STARVELIMIT=4: cpuReq and ioReq both held high for 12 cycles -> ioGnt on cycles 5 and 10 only; cpuStall high on exactly those cycles; starveCnt sequence 1,2,3,4,0,...
- Simultaneous request with starveCnt=0 -> CPU wins and ioGnt=0. ioReq dropped at starveCnt=2 -> count returns to 0 and no ioRvalid appears.
- Reset mid-read: IO read granted, reset pulled low before the next edge -> ioRvalid stays 0 after reset release.
